// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and default constants
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 868;
  localparam int DATA_WIDTH_DEFAULT   = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_reader_if.sv
// rtl/uart_tx_fifo_reader_if.sv - FIFO read-side handshake between the byte FIFO and its consumer
interface uart_tx_fifo_reader_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd_en;

  modport master (input fifo_empty, input fifo_data, output fifo_rd_en);
  modport slave  (output fifo_empty, output fifo_data, input fifo_rd_en);
endinterface

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter with synchronous clear and terminal-count tick
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic tick_o
);
  localparam int             CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  TC = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == TC) && !clear_i;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_tx_fifo_reader.sv
// rtl/uart_tx_fifo_reader.sv - UART transmitter that pops bytes from the FIFO and serialises them
module uart_tx_fifo_reader
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEFAULT,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  uart_tx_fifo_reader_if.master  fifo,
  output logic                   tx,
  output logic                   busy,
  output logic                   tx_done
);
  localparam int             IW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(DATA_WIDTH - 1);

  tx_state_t             state_q, state_d;
  logic                  tx_q, tx_d;
  logic                  rd_en_q, rd_en_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IW-1:0]         bit_idx_q, bit_idx_d;
  logic                  stop_idx_q, stop_idx_d;
  logic                  tick;
  logic                  baud_clear;
  logic                  parity;

  // The baud counter only runs while a bit is on the line, so START always gets a full period.
  assign baud_clear = (state_q == IDLE) || (state_q == POP) || (state_q == LOAD);

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear_i (baud_clear),
    .tick_o  (tick)
  );

  assign parity = (^data_q) ^ (PARITY_ODD != 0);

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rd_en_d    = 1'b0;
    done_d     = 1'b0;
    shift_d    = shift_q;
    data_d     = data_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (enable && !fifo.fifo_empty) begin
          state_d = POP;
          rd_en_d = 1'b1;
        end
      end
      POP:  state_d = LOAD;
      LOAD: begin
        shift_d    = fifo.fifo_data;
        data_d     = fifo.fifo_data;
        tx_d       = 1'b0;
        bit_idx_d  = '0;
        stop_idx_d = 1'b0;
        state_d    = START;
      end
      START: begin
        if (tick) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx_q == LAST_IDX) begin
            if (PARITY_EN != 0) begin
              tx_d    = parity;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            bit_idx_d = bit_idx_q + IW'(1);
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if ((STOP_BITS == 1) || (stop_idx_q == 1'b1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      rd_en_q    <= 1'b0;
      done_q     <= 1'b0;
      shift_q    <= '0;
      data_q     <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rd_en_q    <= rd_en_d;
      done_q     <= done_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
    end
  end

  assign fifo.fifo_rd_en = rd_en_q;
  assign tx              = tx_q;
  assign tx_done         = done_q;
  assign busy            = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// tb/tb_uart_tx_fifo_reader.sv - scoreboard bench: 8N1, 8E1 and 8O2 instances at 4 clocks per bit
`timescale 1ns/1ps
module tb_uart_tx_fifo_reader;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] en  = 3'b000;
  logic [2:0] tx_w, busy_w, done_w, rd_w;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;

  logic [15:0] exp_q  [3][$];
  logic [7:0]  fifo_q [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int NB = 10 + ((g > 0) ? 1 : 0) + ((g == 2) ? 1 : 0);
    logic       fempty = 1'b1;
    logic [7:0] fdata  = 8'h00;
    logic       rd_prev = 1'b0;
    int rd_cnt = 0, rd_hi = 0, rd_cyc = 0, gap = 0, last_done = -1000, aborts = 0;

    uart_tx_fifo_reader_if #(.DATA_WIDTH(8)) fif ();
    assign fif.fifo_empty = fempty;
    assign fif.fifo_data  = fdata;
    assign rd_w[g]        = fif.fifo_rd_en;

    uart_tx_fifo_reader #(
      .CLKS_PER_BIT (4),
      .DATA_WIDTH   (8),
      .PARITY_EN    ((g > 0) ? 1 : 0),
      .PARITY_ODD   ((g == 2) ? 1 : 0),
      .STOP_BITS    ((g == 2) ? 2 : 1)
    ) dut (
      .clk     (clk),
      .rst     (rst),
      .enable  (en[g]),
      .fifo    (fif),
      .tx      (tx_w[g]),
      .busy    (busy_w[g]),
      .tx_done (done_w[g])
    );

    always @(posedge clk) begin
      if (rd_w[g] === 1'b1 && fifo_q[g].size() > 0) fdata <= fifo_q[g].pop_front();
    end

    always @(negedge clk) begin
      if (rd_w[g] === 1'b1) begin
        check("rd_when_empty", fempty, 1'b0);
        rd_hi++;
        if (!rd_prev) rd_cnt++;
        rd_cyc = cyc;
      end
      rd_prev = rd_w[g];
      fempty  = (fifo_q[g].size() == 0);
    end

    always begin : rx
      logic [63:0] st, dn, bz;
      logic [15:0] fv;
      logic        ab;
      int          glitch;
      @(negedge clk);
      if (!rst && tx_w[g] === 1'b0) begin
        ab = 1'b0; st = '0; dn = '0; bz = '0;
        gap = cyc - last_done;
        check("pop_to_tx", cyc - rd_cyc, 2);
        for (int j = 0; j <= NB * 4; j++) begin
          if (j > 0) @(negedge clk);
          if (rst) begin
            ab = 1'b1;
            break;
          end
          st[j] = tx_w[g]; dn[j] = done_w[g]; bz[j] = busy_w[g];
        end
        if (ab) aborts++;
        else begin
          fv = '0; glitch = 0;
          for (int k = 0; k < NB; k++) begin
            fv[k] = st[4*k];
            for (int s = 1; s < 4; s++) if (st[4*k+s] !== st[4*k]) glitch++;
          end
          check("bit_width", glitch, 0);
          if (exp_q[g].size() == 0) check("frame_unexpected", fv, 32'hFFFF_FFFF);
          else                      check("frame", fv, exp_q[g].pop_front());
          check("done_early", |dn[NB*4-1:0], 1'b0);
          check("done_pulse", dn[NB*4], 1'b1);
          check("busy_in_frame", &bz[NB*4-1:0], 1'b1);
          check("busy_after", bz[NB*4], 1'b0);
          last_done = cyc;
        end
      end
    end
  end

  task automatic push(input int g, input logic [7:0] b, input logic [15:0] frame, input bit expect_it);
    fifo_q[g].push_back(b);
    if (expect_it) exp_q[g].push_back(frame);
  endtask

  task automatic drain(input int g);
    int n;
    n = 0;
    while (exp_q[g].size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", exp_q[g].size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_fall0();
    int n;
    n = 0;
    while (tx_w[0] !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("fall_timeout", tx_w[0], 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int viol;
    repeat (3) @(negedge clk);
    check("rst_tx", tx_w, 3'b111);
    check("rst_busy", busy_w, 3'b000);
    check("rst_rd", rd_w, 3'b000);
    check("rst_done", done_w, 3'b000);
    rst = 1'b0;
    en  = 3'b111;

    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_w !== 3'b111 || busy_w !== 3'b000 || rd_w !== 3'b000) viol++;
    end
    check("empty_idle", viol, 0);

    push(0, 8'hA5, 16'h034A, 1'b1);
    push(1, 8'hA5, 16'h054A, 1'b1);
    push(2, 8'hA5, 16'h0F4A, 1'b1);
    drain(0); drain(1); drain(2);
    check("rd_cnt0", inst[0].rd_cnt, 1);
    check("rd_cnt1", inst[1].rd_cnt, 1);
    check("rd_cnt2", inst[2].rd_cnt, 1);

    push(2, 8'h00, 16'h0E00, 1'b1);
    push(2, 8'hFF, 16'h0FFE, 1'b1);
    drain(2);
    check("s2_rd_cnt", inst[2].rd_cnt, 3);
    check("s2_rd_width", inst[2].rd_hi, 3);
    check("s2_gap", inst[2].gap, 3);

    push(0, 8'h3C, 16'h0278, 1'b1);
    push(0, 8'h11, 16'h0000, 1'b0);
    wait_fall0();
    repeat (17) @(negedge clk);
    en[0] = 1'b0;
    drain(0);
    repeat (40) @(negedge clk);
    check("en_off_rd_cnt", inst[0].rd_cnt, 2);
    check("en_off_left", fifo_q[0].size(), 1);
    check("en_off_busy", busy_w[0], 1'b0);

    en[0] = 1'b1;
    wait_fall0();
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_tx", tx_w[0], 1'b1);
    check("arst_busy", busy_w[0], 1'b0);
    check("arst_done", done_w[0], 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    check("arst_abort", inst[0].aborts, 1);
    push(0, 8'h5A, 16'h02B4, 1'b1);
    drain(0);
    check("rd_cnt_final", inst[0].rd_cnt, 4);
    check("rd_width0", inst[0].rd_hi, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo_reader.md
Name: uart_tx_fifo_reader

Overview:
- UART transmitter that drains the byte FIFO (fifo, 8x8) and serializes each byte onto the tx line.
- Sits on the FIFO read side and acts as its consumer:
  - pops one entry via a single-cycle read strobe;
  - captures the FIFO's registered data_out one cycle later;
  - emits an 8N1 frame by default, with optional parity and a second stop bit.
- Runs continuously while enabled and the FIFO is non-empty.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range >= 2.
- DATA_WIDTH, 8, data bits per frame; must equal the FIFO memory_widht.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  permits new frames to start; sampled only in IDLE.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  DATA_WIDTH  FIFO data_out; valid the cycle after fifo_rd_en.
- fifo_rd_en  output  1  registered one-cycle pop strobe to the FIFO read enable.
- tx  output  1  serial line; idles high; registered.
- busy  output  1  high in every state except IDLE.
- tx_done  output  1  one-cycle pulse when the last stop bit completes.

Behaviour:
- Reset values (async on rst=1; the effect is immediate, mid-frame included):
  - tx=1, fifo_rd_en=0, busy=0, tx_done=0;
  - state=IDLE, baud counter=0, bit index=0, shift register=0.
  - A frame in progress is abandoned with no partial stop bit.
  - The popped byte is lost.
- States: IDLE, POP, LOAD, START, DATA, PARITY, STOP.
- IDLE:
  - If enable=1 and fifo_empty=0 at edge E0, go to POP.
  - Otherwise stay; tx=1.
- POP:
  - fifo_rd_en=1 for exactly this one cycle.
  - At edge E1 the FIFO registers data_out; go to LOAD.
- LOAD:
  - At edge E2 the shift register captures fifo_data, tx is driven 0, go to START.
  - tx falling edge is therefore 2 edges after E0.
- Bit timing:
  - START, each DATA bit, PARITY and each STOP bit hold tx for exactly CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1 and the bit advances on terminal count.
  - Counter width is $clog2(CLKS_PER_BIT).
- DATA:
  - LSB first; the shift register shifts right on each bit boundary.
  - Bit index runs 0..DATA_WIDTH-1 (width $clog2(DATA_WIDTH)).
  - After the last bit, go to PARITY if PARITY_EN, else STOP.
- PARITY:
  - tx = XOR of the captured byte, XOR PARITY_ODD.
  - Computed from the captured byte, not from the shifting register.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the final terminal count: tx_done=1 for one cycle, state goes to IDLE.
- Back-to-back frames:
  - IDLE re-evaluates on the cycle following tx_done.
  - Minimum inter-frame gap is 3 cycles of tx=1 beyond the stop bits (IDLE, POP and LOAD cycles).
- Boundary conditions:
  - enable deasserted mid-frame: the current frame completes normally; no new pop.
  - fifo_empty going 1 during LOAD or later: no effect on the current frame.
  - fifo_rd_en is never asserted when fifo_empty was 1 at the IDLE decision edge.
  - The FIFO's own read-enable path must accept a single-cycle strobe directly, with no debouncer edge-detect.
- No combinational path from any input to any output.

Decomposition:
- Shared package uart_pkg:
  - state enum tx_state_t (IDLE, POP, LOAD, START, DATA, PARITY, STOP);
  - default constants CLKS_PER_BIT_DEFAULT=868 and DATA_WIDTH_DEFAULT=8.
  - Reused by the future uart_rx.
- One sub-module, uart_baud_gen:
  - parameterised CLKS_PER_BIT counter with clear and a terminal-count tick output;
  - async reset.
- FSM, shift register and parity stay in the top module.

Test Plan:
Bench uses CLKS_PER_BIT=4.
1. Reset, enable=1, FIFO preloaded with 0xA5:
   - fifo_rd_en pulses exactly 1 cycle;
   - tx falls 2 edges later, then tx sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1;
   - tx_done pulses once at cycle 40 after the tx falling edge; busy low afterwards.
2. PARITY_EN=1, PARITY_ODD=0, byte 0xA5 -> parity bit 0; with PARITY_ODD=1 -> parity bit 1. Frame is 11 bits (44 cycles).
3. STOP_BITS=2, bytes 0x00 then 0xFF queued:
   - both frames are sent; each has 8 stop cycles high;
   - exactly 3 extra idle-high cycles between frames;
   - fifo_rd_en pulses twice total.
4. enable=1, fifo_empty=1 held for 100 cycles -> fifo_rd_en never asserted, tx stays 1, busy stays 0.
5. enable dropped during DATA bit 3 of 0x3C -> frame finishes with the correct bits; no further pop although the FIFO is non-empty.
6. rst asserted mid-DATA (asynchronously, between edges) -> tx=1 and busy=0 immediately; after release with the FIFO non-empty, a fresh complete frame starts.
